cpu_cmd_encoder: RTL and testbench

- Transmit-side companion to the 8-bit `cpu` instruction port: serializes decoded commands into the byte stream the `cpu` consumes on its `in` port.
- Accepts commands (opcode, address, data) through a valid/ready handshake and buffers them in a small FIFO.
- Emits one byte per clock: 1-byte instructions, or opcode byte plus operand byte for 2-byte instructions.
- Drives a non-modifying idle byte whenever there is nothing to send.

---
 rtl/cpu_cmd_encoder.sv | 187 ++++++++++++++++++
 tb/tb_cpu_cmd_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_cmd_encoder
// Purpose  : Serializes decoded commands (opcode, address, data) into the
//            byte stream consumed by the 8-bit cpu instruction port. Commands
//            are buffered in a small FIFO. One byte is emitted per clock, and
//            an idle byte is driven when there is nothing to send.
// Ports    : clk, reset (sync, active-low)
//            cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data - command input
//            cpu_in[7:0], cpu_in_sof - registered byte stream and first-byte flag
//            busy - FIFO non-empty or operand byte pending
//            err  - one-cycle pulse when a reserved opcode (4'hF) is dropped
//            tx_count[15:0] - wrapping count of non-idle bytes emitted
// Revision : 1.0 - initial release
// ============================================================================
module cpu_cmd_encoder #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] IDLE_BYTE  = 8'hB0,
    parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic [7:0]  cpu_in,
    output logic        cpu_in_sof,
    output logic        busy,
    output logic        err,
    output logic [15:0] tx_count
);

    localparam int              AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]     C_DEPTH     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     C_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   C_PTR_ONE   = AW'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_OPERAND = 1'b1
    } state_t;

    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_operand;
    logic [7:0]    w_operand_nxt;
    logic [7:0]    r_cpu_in;
    logic [7:0]    w_cpu_in_nxt;
    logic          r_sof;
    logic          w_sof_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic [15:0]   r_tx_count;
    logic          w_tx_inc;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_head;
    logic [3:0]    w_head_op;
    logic [3:0]    w_head_addr;
    logic [7:0]    w_head_data;
    logic [3:0]    w_lo;
    logic          w_two_byte;
    logic          w_use_data;

    assign cmd_ready  = reset && (r_count != C_DEPTH);
    assign w_push     = cmd_valid && cmd_ready;
    assign busy       = (r_count != '0) || (r_state == ST_OPERAND);
    assign cpu_in     = r_cpu_in;
    assign cpu_in_sof = r_sof;
    assign err        = r_err;
    assign tx_count   = r_tx_count;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[15:12];
    assign w_head_addr = w_head[11:8];
    assign w_head_data = w_head[7:0];

    // Opcode decode: low nibble of the first byte and the operand source.
    always_comb begin
        w_lo       = 4'h0;
        w_two_byte = 1'b0;
        w_use_data = 1'b0;
        case (w_head_op)
            4'h6, 4'h7: begin
                w_lo       = 4'hF;
                w_two_byte = 1'b1;
                w_use_data = 1'b1;
            end
            4'h8: begin
                w_lo       = w_head_addr;
                w_two_byte = 1'b1;
                w_use_data = 1'b1;
            end
            4'h9:       w_lo = w_head_addr;
            4'hA, 4'hC: begin
                // Reserved second byte: padded rather than taken from data.
                w_lo       = w_head_addr;
                w_two_byte = 1'b1;
            end
            4'hB:       w_lo = 4'hF;
            default:    w_lo = 4'h0;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_operand_nxt = r_operand;
        w_cpu_in_nxt  = IDLE_BYTE;
        w_sof_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_tx_inc      = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    if (w_head_op == 4'hF) begin
                        // Reserved opcode: dropped, idle byte stays on the bus.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_cpu_in_nxt = {w_head_op, w_lo};
                        w_sof_nxt    = 1'b1;
                        w_tx_inc     = 1'b1;
                        if (w_two_byte) begin
                            w_state_nxt   = ST_OPERAND;
                            w_operand_nxt = w_use_data ? w_head_data : PAD_BYTE;
                        end
                    end
                end
            end
            ST_OPERAND: begin
                w_cpu_in_nxt = r_operand;
                w_tx_inc     = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_state    <= ST_IDLE;
            r_operand  <= PAD_BYTE;
            r_cpu_in   <= IDLE_BYTE;
            r_sof      <= 1'b0;
            r_err      <= 1'b0;
            r_tx_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_state   <= w_state_nxt;
            r_operand <= w_operand_nxt;
            r_cpu_in  <= w_cpu_in_nxt;
            r_sof     <= w_sof_nxt;
            r_err     <= w_err_nxt;
            if (w_tx_inc) begin
                r_tx_count <= r_tx_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_cmd_encoder
// Purpose  : Self-checking bench for cpu_cmd_encoder. Each accepted command is
//            expanded into the bytes it must produce; a monitor compares every
//            emitted byte, idle cycles, cmd_ready and busy against that list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_cmd_encoder;

    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'hB0;
    localparam logic [7:0] PAD   = 8'hFF;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  cpu_in;
    logic        cpu_in_sof;
    logic        busy;
    logic        err;
    logic [15:0] tx_count;

    typedef struct packed {
        logic [7:0] b;
        logic       sof;
        logic       is_err;
    } exp_t;

    exp_t        q[$];
    int          n_checks;
    int          n_err;
    int          n_pushed;
    int          n_popped;
    int          exp_tx;
    logic [15:0] prev_tx;
    logic        mon_en;

    cpu_cmd_encoder #(
        .FIFO_DEPTH (DEPTH),
        .IDLE_BYTE  (IDLE),
        .PAD_BYTE   (PAD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cpu_in     (cpu_in),
        .cpu_in_sof (cpu_in_sof),
        .busy       (busy),
        .err        (err),
        .tx_count   (tx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the bytes a command must produce on the stream.
    task automatic model_push(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] data);
        exp_t       e;
        logic [3:0] lo;
        if (op == 4'hF) begin
            e.b = IDLE; e.sof = 1'b0; e.is_err = 1'b1;
            q.push_back(e);
        end else begin
            if (op inside {4'h8, 4'h9, 4'hA, 4'hC})      lo = addr;
            else if (op inside {4'h6, 4'h7, 4'hB})       lo = 4'hF;
            else                                         lo = 4'h0;
            e.b = {op, lo}; e.sof = 1'b1; e.is_err = 1'b0;
            q.push_back(e);
            if (op inside {4'h6, 4'h7, 4'h8}) begin
                e.b = data; e.sof = 1'b0; e.is_err = 1'b0;
                q.push_back(e);
            end else if (op inside {4'hA, 4'hC}) begin
                e.b = PAD; e.sof = 1'b0; e.is_err = 1'b0;
                q.push_back(e);
            end
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] data);
        int waits;
        waits = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        #1;
        while (!cmd_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got ready=%b expected ready=1", cmd_ready);
        end else begin
            model_push(op, addr, data);
            n_pushed++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        mon_en    = 1'b0;
        cmd_valid = 1'b0;
        reset     = 1'b0;
        #1;
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_cpu_in", 32'(cpu_in), 32'(IDLE));
        chk("rst_sof", 32'(cpu_in_sof), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        q.delete();
        n_pushed = 0;
        n_popped = 0;
        exp_tx   = 0;
        prev_tx  = 16'd0;
        reset    = 1'b1;
        @(negedge clk);
        #2;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);
        mon_en = 1'b1;
    endtask

    // Monitor: an output is presented when tx_count moves or err pulses.
    initial begin
        exp_t e;
        int   occ;
        logic pres;
        logic busy_exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                pres = (tx_count !== prev_tx) || (err === 1'b1);
                if (pres) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_output: got cpu_in=%h sof=%b err=%b expected nothing", cpu_in, cpu_in_sof, err);
                    end else begin
                        e = q.pop_front();
                        if (e.is_err) begin
                            chk("drop_err", 32'(err), 32'd1);
                            chk("drop_cpu_in", 32'(cpu_in), 32'(IDLE));
                            chk("drop_sof", 32'(cpu_in_sof), 32'd0);
                            chk("drop_tx_count", 32'(tx_count), 32'(exp_tx[15:0]));
                            n_popped++;
                        end else begin
                            exp_tx++;
                            chk("byte", 32'(cpu_in), 32'(e.b));
                            chk("sof", 32'(cpu_in_sof), 32'(e.sof));
                            chk("err_low", 32'(err), 32'd0);
                            chk("tx_count", 32'(tx_count), 32'(exp_tx[15:0]));
                            if (e.sof) n_popped++;
                        end
                    end
                end else begin
                    chk("idle", {23'd0, cpu_in, cpu_in_sof}, {23'd0, IDLE, 1'b0});
                end
                occ      = n_pushed - n_popped;
                busy_exp = (occ != 0);
                if (q.size() > 0) begin
                    if (!q[0].sof && !q[0].is_err) busy_exp = 1'b1;
                end
                chk("cmd_ready", 32'(cmd_ready), 32'(occ != DEPTH));
                chk("busy", 32'(busy), 32'(busy_exp));
                prev_tx = tx_count;
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_err     = 0;
        n_pushed  = 0;
        n_popped  = 0;
        exp_tx    = 0;
        prev_tx   = 16'd0;
        mon_en    = 1'b0;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_addr  = 4'h0;
        cmd_data  = 8'h00;
        repeat (2) @(negedge clk);
        do_reset();

        // Single 2-byte command: latency and no bypass.
        send(4'h6, 4'h3, 8'hFF);
        @(negedge clk); cmd_valid = 1'b0; #1;
        chk("no_bypass", 32'(cpu_in), 32'(IDLE));
        @(negedge clk); #1;
        chk("lat_first", {23'd0, cpu_in, cpu_in_sof}, {23'd0, 8'h6F, 1'b1});
        @(negedge clk); #1;
        chk("lat_second", {23'd0, cpu_in, cpu_in_sof}, {23'd0, 8'hFF, 1'b0});
        @(negedge clk); #1;
        chk("lat_idle", 32'(cpu_in), 32'(IDLE));
        chk("lat_tx_count", 32'(tx_count), 32'd2);

        // Back-to-back 1-byte commands.
        for (int i = 0; i < 6; i++) send(4'(i), 4'(i + 3), 8'(i * 17));
        idle(10);

        // Address-carrying 2-byte commands with data and pad operands.
        send(4'h8, 4'hF, 8'hA5);
        send(4'hA, 4'hF, 8'h12);
        send(4'hC, 4'h3, 8'h34);
        idle(10);

        // Sustained 2-byte traffic to hit the full condition.
        for (int i = 0; i < 12; i++) send(4'h7, 4'(i), 8'(8'hB0 + i));
        idle(30);

        // Reserved opcode between two 1-byte commands.
        send(4'hB, 4'h1, 8'h00);
        send(4'hF, 4'h2, 8'h00);
        send(4'hD, 4'h3, 8'h00);
        idle(10);

        // Reset while an operand is pending and two commands are queued.
        for (int i = 0; i < 4; i++) send(4'h7, 4'h0, 8'(8'h40 + i));
        do_reset();
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(40);

        chk("drain_queue_empty", 32'(q.size()), 32'd0);
        chk("final_tx_count", 32'(tx_count), 32'(exp_tx[15:0]));
        chk("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
